// File: rtl/alarm_ctrl.sv
`default_nettype none
// alarm_ctrl: user-interface sequencer for the alarm clock (time/alarm editing, commit, match, ring, snooze).
// Revision 1.0
module alarm_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_set,
  input  logic [3:0] cur_hr_t,
  input  logic [3:0] cur_hr_o,
  input  logic [3:0] cur_min_t,
  input  logic [3:0] cur_min_o,
  input  logic [3:0] cur_sec_t,
  input  logic [3:0] cur_sec_o,
  output logic       load_en,
  output logic [3:0] load_hr_t,
  output logic [3:0] load_hr_o,
  output logic [3:0] load_min_t,
  output logic [3:0] load_min_o,
  output logic [3:0] alm_hr_t,
  output logic [3:0] alm_hr_o,
  output logic [3:0] alm_min_t,
  output logic [3:0] alm_min_o,
  output logic [3:0] edit_hr_t,
  output logic [3:0] edit_hr_o,
  output logic [3:0] edit_min_t,
  output logic [3:0] edit_min_o,
  output logic [1:0] mode,
  output logic       edit_field,
  output logic       blink,
  output logic       armed,
  output logic       buzzer
);
  localparam int CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RING_LD = CW'(RING_SEC);
  localparam logic [CW-1:0] SNZ_LD  = CW'(SNOOZE_SEC);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    S_RUN        = 3'd0,
    S_EDIT_TIME  = 3'd1,
    S_EDIT_ALARM = 3'd2,
    S_RINGING    = 3'd3,
    S_SNOOZE     = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [15:0]     edit_q, edit_n, alm_q, alm_n, load_q, load_n, cur_hm;
  logic [CW-1:0]   cnt, cnt_n;
  logic [1:0]      mode_n;
  logic            field_n, blink_n, armed_n, load_en_n, match, match_d;

  // BCD increments with per-field wrap and no carry into the other field
  function automatic logic [7:0] inc_hr(input logic [7:0] v);
    if (v == 8'h23)             return 8'h00;
    else if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    else                        return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_min(input logic [7:0] v);
    if (v == 8'h59)             return 8'h00;
    else if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    else                        return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign cur_hm = {cur_hr_t, cur_hr_o, cur_min_t, cur_min_o};
  assign match  = armed && (cur_hm == alm_q) && (cur_sec_t == 4'd0) && (cur_sec_o == 4'd0);

  assign {load_hr_t, load_hr_o, load_min_t, load_min_o} = load_q;
  assign {alm_hr_t, alm_hr_o, alm_min_t, alm_min_o}     = alm_q;
  assign {edit_hr_t, edit_hr_o, edit_min_t, edit_min_o} = edit_q;

  always_comb begin
    state_n   = state;
    edit_n    = edit_q;
    alm_n     = alm_q;
    load_n    = load_q;
    field_n   = edit_field;
    blink_n   = blink;
    armed_n   = armed;
    load_en_n = 1'b0;
    cnt_n     = cnt;
    mode_n    = 2'd0;
    case (state)
      S_RUN: begin
        // An alarm edge outranks a simultaneous mode press so it is never missed
        if (match && !match_d) begin
          state_n = S_RINGING;
          cnt_n   = RING_LD;
        end else if (!btn_set && !btn_inc && btn_mode) begin
          state_n = S_EDIT_TIME;
          edit_n  = cur_hm;
          field_n = 1'b0;
          blink_n = 1'b0;
        end
      end
      S_EDIT_TIME, S_EDIT_ALARM: begin
        if (btn_set) begin
          if (!edit_field) begin
            field_n = 1'b1;
          end else begin
            state_n = S_RUN;
            field_n = 1'b0;
            blink_n = 1'b0;
            if (state == S_EDIT_TIME) begin
              load_n    = edit_q;
              load_en_n = 1'b1;
            end else begin
              alm_n   = edit_q;
              armed_n = 1'b1;
            end
          end
        end else if (btn_inc) begin
          if (!edit_field) edit_n[15:8] = inc_hr(edit_q[15:8]);
          else             edit_n[7:0]  = inc_min(edit_q[7:0]);
        end else if (btn_mode) begin
          field_n = 1'b0;
          blink_n = 1'b0;
          if (state == S_EDIT_TIME) begin
            state_n = S_EDIT_ALARM;
            edit_n  = alm_q;
          end else begin
            state_n = S_RUN;
          end
        end else if (tick_1hz) begin
          blink_n = !blink;
        end
      end
      S_RINGING: begin
        if (btn_set) begin
          state_n = S_RUN;
          cnt_n   = '0;
        end else if (btn_inc) begin
          state_n = S_SNOOZE;
          cnt_n   = SNZ_LD;
        end else if (tick_1hz) begin
          if (cnt <= CNT_ONE) begin
            state_n = S_RUN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end
      end
      S_SNOOZE: begin
        if (btn_set) begin
          state_n = S_RUN;
          cnt_n   = '0;
        end else if (tick_1hz) begin
          if (cnt <= CNT_ONE) begin
            state_n = S_RINGING;
            cnt_n   = RING_LD;
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end
      end
      default: state_n = S_RUN;
    endcase
    case (state_n)
      S_EDIT_TIME:          mode_n = 2'd1;
      S_EDIT_ALARM:         mode_n = 2'd2;
      S_RINGING, S_SNOOZE:  mode_n = 2'd3;
      default:              mode_n = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      edit_q     <= '0;
      alm_q      <= '0;
      load_q     <= '0;
      cnt        <= '0;
      edit_field <= 1'b0;
      blink      <= 1'b0;
      armed      <= 1'b0;
      load_en    <= 1'b0;
      match_d    <= 1'b0;
      mode       <= 2'd0;
      buzzer     <= 1'b0;
    end else begin
      state      <= state_n;
      edit_q     <= edit_n;
      alm_q      <= alm_n;
      load_q     <= load_n;
      cnt        <= cnt_n;
      edit_field <= field_n;
      blink      <= blink_n;
      armed      <= armed_n;
      load_en    <= load_en_n;
      match_d    <= match;
      mode       <= mode_n;
      buzzer     <= (state_n == S_RINGING);
    end
  end
endmodule
`default_nettype wire
